// File: rtl/mtm_alu_pkg.sv
// Serial-link definitions shared by the MTM ALU deserializer and serializer.
// Every packet is {start, type, payload[7:0], stop}, sent MSB first.
package mtm_alu_pkg;

    localparam int   PKT_BITS  = 11;
    localparam logic PKT_DATA  = 1'b0;
    localparam logic PKT_CTL   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_CTL,
        ST_DONE
    } state_t;

    function automatic logic [PKT_BITS-1:0] make_pkt(input logic pkt_type, input logic [7:0] payload);
        return {START_BIT, pkt_type, payload, STOP_BIT};
    endfunction

endpackage

// File: rtl/mtm_alu_pkt_tx.sv
// Packet transmitter: an 11-bit load/shift register with a bit counter.
// The line idles high because the register shifts in stop bits.
module mtm_alu_pkt_tx
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic       pkt_type,
    input  logic [7:0] payload,
    output logic       sout,
    output logic       last_bit
);

    localparam int CW = $clog2(PKT_BITS);

    logic [PKT_BITS-1:0] pkt_q;
    logic [CW-1:0]       bit_cnt;

    assign sout     = pkt_q[PKT_BITS-1];
    assign last_bit = (bit_cnt == CW'(PKT_BITS - 1));

    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_q   <= '1;
            bit_cnt <= '0;
        end else if (load) begin
            pkt_q   <= make_pkt(pkt_type, payload);
            bit_cnt <= '0;
        end else if (shift) begin
            pkt_q   <= {pkt_q[PKT_BITS-2:0], STOP_BIT};
            bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// MTM ALU output stage: latches one (C, CTL) result and sends it as DATA packets, MSB byte first,
// followed by one CTL packet. An error result (CTL[7]=1) sends only the CTL packet.
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*DATA_BYTES-1:0] C,
    input  logic [7:0]              CTL,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    sout,
    output logic                    busy,
    output logic                    done
);

    localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(DATA_BYTES - 1);

    state_t                  state;
    logic [BCW-1:0]          byte_cnt;
    logic [BCW-1:0]          byte_sel;
    logic [8*DATA_BYTES-1:0] c_q;
    logic [7:0]              ctl_q;
    logic                    load;
    logic                    shift;
    logic                    ld_type;
    logic [7:0]              ld_byte;
    logic                    last_bit;

    assign in_ready = (state == ST_IDLE);
    assign shift    = (state == ST_DATA) || (state == ST_CTL);
    assign byte_sel = BCW'(DATA_BYTES - 2) - byte_cnt;

    // The first packet loads straight from the inputs so its start bit leaves one cycle after accept.
    // NOTE: every always_comb output gets a default first, otherwise untaken branches infer latches.
    always_comb begin
        load    = 1'b0;
        ld_type = PKT_DATA;
        ld_byte = C[8*DATA_BYTES-1 -: 8];
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                    if (CTL[7]) begin
                        ld_type = PKT_CTL;
                        ld_byte = CTL;
                    end
                end
            end
            ST_DATA: begin
                if (last_bit) begin
                    load = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        ld_type = PKT_CTL;
                        ld_byte = ctl_q;
                    end else begin
                        ld_byte = 8'(c_q >> {byte_sel, 3'b000});
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            c_q      <= '0;
            ctl_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        c_q      <= C;
                        ctl_q    <= CTL;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= CTL[7] ? ST_CTL : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (last_bit) begin
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            state    <= ST_CTL;
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
                ST_CTL: begin
                    if (last_bit) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mtm_alu_pkt_tx u_pkt_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .pkt_type (ld_type),
        .payload  (ld_byte),
        .sout     (sout),
        .last_bit (last_bit)
    );

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Scoreboard bench for mtm_alu_serializer: the driver queues expected results, and a frame decoder
// on sout pops and compares them. Frame timing is checked against hand-derived cycle offsets.
module tb_mtm_alu_serializer;

    typedef struct packed {
        logic [31:0] c;
        logic [7:0]  ctl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] C = '0;
    logic [7:0]  CTL = '0;
    logic        in_ready, sout, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t exp_q[$];
    int   acc_cycs[$];
    int   start_cycs[$];
    int   done_cycs[$];

    // frame decoder state
    logic        in_pkt = 1'b0;
    logic        frame_open = 1'b0;
    int          pcnt = 0;
    int          ndata = 0;
    logic [10:0] shreg = '0;
    logic [31:0] data_buf = '0;
    logic [54:0] frame_bits = '0;
    int          frame_len = 0;
    logic [54:0] last_bits = '0;
    int          last_len = 0;

    mtm_alu_serializer #(.DATA_BYTES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .C        (C),
        .CTL      (CTL),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sout     (sout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame decoder: every 0 on an idle line opens an 11-bit packet.
    always @(negedge clk) begin
        if (rst) begin
            in_pkt     = 1'b0;
            frame_open = 1'b0;
            ndata      = 0;
        end else if (!in_pkt) begin
            if (sout !== 1'b1) begin
                in_pkt = 1'b1;
                pcnt   = 1;
                shreg  = {10'b0, sout};
                if (!frame_open) begin
                    frame_open = 1'b1;
                    frame_bits = '0;
                    frame_len  = 0;
                    start_cycs.push_back(cyc);
                end
                frame_bits = {frame_bits[53:0], sout};
                frame_len++;
            end
        end else begin
            shreg = {shreg[9:0], sout};
            pcnt++;
            frame_bits = {frame_bits[53:0], sout};
            frame_len++;
            if (pcnt == 11) begin
                in_pkt = 1'b0;
                check("stop_bit", shreg[0], 1'b1);
                if (shreg[9] == 1'b0) begin
                    data_buf = {data_buf[23:0], shreg[8:1]};
                    ndata++;
                end else begin
                    frame_open = 1'b0;
                    last_bits  = frame_bits;
                    last_len   = frame_len;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got ctl 0x%0h with %0d data bytes, expected no frame", shreg[8:1], ndata);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("frame_ndata", ndata, e.ctl[7] ? 0 : 4);
                        if (!e.ctl[7]) check("frame_c", data_buf, e.c);
                        check("frame_ctl", shreg[8:1], e.ctl);
                    end
                    ndata = 0;
                end
            end
        end
    end

    always @(negedge clk) if (!rst && done === 1'b1) done_cycs.push_back(cyc);

    // Offer one result; returns at the negedge after the accept edge.
    task automatic send(input logic [31:0] c, input logic [7:0] ctl, input bit hold);
        int n;
        exp_t e;
        n = 0;
        C = c;
        CTL = ctl;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end else begin
            e.c = c;
            e.ctl = ctl;
            exp_q.push_back(e);
            acc_cycs.push_back(cyc);
        end
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int rdy_cyc);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end
        rdy_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        acc_cycs.delete();
        start_cycs.delete();
        done_cycs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy;
        int zc;

        // power-up reset
        repeat (3) @(negedge clk);
        check("rst_sout", sout, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // success frame with hand-computed bit stream
        clear_logs();
        send(32'h12345678, 8'h0B, 1'b0);
        check("busy_mid_frame", busy, 1'b1);
        wait_idle(rdy);
        check("ok_len", last_len, 55);
        check("ok_bits", last_bits,
              55'b0_0_00010010_1_0_0_00110100_1_0_0_01010110_1_0_0_01111000_1_0_1_00001011_1);
        check("ok_done_count", done_cycs.size(), 1);
        if (acc_cycs.size() == 1 && start_cycs.size() == 1 && done_cycs.size() == 1) begin
            check("ok_start_latency", start_cycs[0] - acc_cycs[0], 1);
            check("ok_done_offset", done_cycs[0] - acc_cycs[0], 56);
            check("ok_ready_offset", rdy - acc_cycs[0], 57);
        end
        check("sb_drain_ok", exp_q.size(), 0);

        // error result: CTL packet only
        clear_logs();
        send(32'hFFFFFFFF, 8'hC9, 1'b0);
        wait_idle(rdy);
        check("err_len", last_len, 11);
        check("err_bits", last_bits[10:0], 11'b0_1_11001001_1);
        check("err_done_count", done_cycs.size(), 1);
        if (start_cycs.size() == 1 && done_cycs.size() == 1)
            check("err_done_after_start", done_cycs[0] - start_cycs[0], 11);
        check("sb_drain_err", exp_q.size(), 0);

        // back-to-back with in_valid held; second result is all-zero data
        clear_logs();
        send(32'hA5A55A5A, 8'h05, 1'b1);
        send(32'h00000000, 8'h00, 1'b0);
        wait_idle(rdy);
        check("b2b_frames", start_cycs.size(), 2);
        if (acc_cycs.size() == 2 && start_cycs.size() == 2) begin
            check("b2b_accept_gap", acc_cycs[1] - acc_cycs[0], 57);
            check("b2b_start_gap", start_cycs[1] - start_cycs[0], 57);
        end
        check("zero_bits", last_bits, {{4{11'b0_0_00000000_1}}, 11'b0_1_00000000_1});
        check("sb_drain_b2b", exp_q.size(), 0);

        // all-ones data boundary
        clear_logs();
        send(32'hFFFFFFFF, 8'h07, 1'b0);
        wait_idle(rdy);
        check("ones_bits", last_bits, {{4{11'b0_0_11111111_1}}, 11'b0_1_00000111_1});
        check("sb_drain_ones", exp_q.size(), 0);

        // input changes and a stray in_valid pulse during transmission are ignored
        clear_logs();
        send(32'hDEADBEEF, 8'h03, 1'b0);
        repeat (8) @(negedge clk);
        C = 32'h00000000;
        CTL = 8'hFF;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        C = 32'h55AA55AA;
        wait_idle(rdy);
        repeat (5) @(negedge clk);
        check("busy_in_frames", start_cycs.size(), 1);
        check("busy_in_dones", done_cycs.size(), 1);
        check("sb_drain_busy", exp_q.size(), 0);

        // reset mid-frame: 3 cycles, then a quiet line
        clear_logs();
        send(32'h11223344, 8'h01, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sout", sout, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        zc = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (sout !== 1'b1) zc++;
        end
        check("midrst_quiet_line", zc, 0);
        check("midrst_no_done", done_cycs.size(), 0);

        // recovery after reset
        clear_logs();
        send(32'h0F0F0F0F, 8'h06, 1'b0);
        wait_idle(rdy);
        check("recover_frames", start_cycs.size(), 1);
        check("sb_drain_recover", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
